// File: rtl/scc_mem_responder.sv
// Memory responder for the SCC core: registered instruction fetch port,
// pipelined data reads, data writes, a back-door load port, sticky fault
// bits and saturating access counters.
//
// Ports:
//   clk, rst, clk_en        clock, sync active-high reset, clock enable
//   programCounter          fetch byte address -> instruction (1 cycle)
//   writeFlag, memoryRead,  data write / read requests, byte address
//   addressIn, dataOut      and write data from the core
//   memoryDataIn, read_valid  read data and its one-cycle valid pulse
//   halt                    blocks new data accesses
//   load_en, load_addr,     back-door word write, also active in reset
//   load_data
//   err_bits                sticky faults: [0] misaligned, [1] out of range
//   rd_count, wr_count      accepted reads / writes, saturating
module scc_mem_responder #(
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [31:0]          programCounter,
  output logic [31:0]          instruction,
  input  logic                 writeFlag,
  input  logic                 memoryRead,
  input  logic [31:0]          addressIn,
  input  logic [31:0]          dataOut,
  output logic [31:0]          memoryDataIn,
  output logic                 read_valid,
  input  logic                 halt,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [31:0]          load_data,
  output logic [1:0]           err_bits,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  // Out-of-range latencies are clamped into the supported 1..4 window.
  localparam int LAT =
    (READ_LATENCY < 1) ? 1 :
    (READ_LATENCY > 4) ? 4 : READ_LATENCY;
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] r_mem [DEPTH];

  logic [31:0]          r_instr;
  logic [1:0]           r_err;
  logic [15:0]          r_rd_cnt;
  logic [15:0]          r_wr_cnt;
  logic                 r_v [LAT];
  logic [31:0]          r_d [LAT];

  logic [ADDR_BITS-1:0] w_pc_idx;
  logic                 w_pc_mis;
  logic                 w_pc_oor;
  logic [31:0]          w_pc_word;

  logic [ADDR_BITS-1:0] w_d_idx;
  logic                 w_d_mis;
  logic                 w_d_oor;
  logic                 w_d_ok;

  logic                 w_wr_req;
  logic                 w_rd_req;
  logic                 w_wr_ok;
  logic [31:0]          w_rd_data;
  logic [1:0]           w_err_set;

  assign w_pc_idx  = programCounter[ADDR_BITS+1:2];
  assign w_pc_mis  = programCounter[1:0] != 2'b00;
  assign w_pc_oor  = programCounter[31:ADDR_BITS+2] != '0;
  assign w_pc_word = r_mem[w_pc_idx];

  assign w_d_idx = addressIn[ADDR_BITS+1:2];
  assign w_d_mis = addressIn[1:0] != 2'b00;
  assign w_d_oor = addressIn[31:ADDR_BITS+2] != '0;
  assign w_d_ok  = !w_d_mis && !w_d_oor;

  assign w_wr_req = writeFlag && !halt;
  assign w_rd_req = memoryRead && !halt;
  assign w_wr_ok  = w_wr_req && w_d_ok;

  // Read capture: back-door load beats a same-cycle core write,
  // which beats the stored word. Faulting reads return zero.
  always_comb begin
    w_rd_data = r_mem[w_d_idx];
    if (w_wr_ok)
      w_rd_data = dataOut;
    if (load_en && load_addr == w_d_idx)
      w_rd_data = load_data;
    if (!w_d_ok)
      w_rd_data = 32'h0;
  end

  always_comb begin
    w_err_set = 2'b00;
    if (w_pc_mis)
      w_err_set[0] = 1'b1;
    if (w_pc_oor)
      w_err_set[1] = 1'b1;
    if ((w_wr_req || w_rd_req) && w_d_mis)
      w_err_set[0] = 1'b1;
    if ((w_wr_req || w_rd_req) && w_d_oor)
      w_err_set[1] = 1'b1;
  end

  // Memory array: no reset, so contents survive rst. The load is
  // written last so it wins over a core write to the same word.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (!rst && w_wr_ok)
        r_mem[w_d_idx] <= dataOut;
      if (load_en)
        r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr  <= 32'h0;
      r_err    <= 2'b00;
      r_rd_cnt <= 16'h0;
      r_wr_cnt <= 16'h0;
    end else if (clk_en) begin
      r_instr <= w_pc_oor ? 32'h0 : w_pc_word;
      r_err   <= r_err | w_err_set;
      if (w_rd_req && r_rd_cnt != 16'hFFFF)
        r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_wr_ok && r_wr_cnt != 16'hFFFF)
        r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  // Read pipeline. Data registers only load alongside a valid bit,
  // so the last stage holds the most recent read between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        r_v[k] <= 1'b0;
        r_d[k] <= 32'h0;
      end
    end else if (clk_en) begin
      r_v[0] <= w_rd_req;
      if (w_rd_req)
        r_d[0] <= w_rd_data;
      for (int k = 1; k < LAT; k++) begin
        r_v[k] <= r_v[k-1];
        if (r_v[k-1])
          r_d[k] <= r_d[k-1];
      end
    end
  end

  assign instruction  = r_instr;
  assign memoryDataIn = r_d[LAT-1];
  assign read_valid   = r_v[LAT-1];
  assign err_bits     = r_err;
  assign rd_count     = r_rd_cnt;
  assign wr_count     = r_wr_cnt;

endmodule
